// File: rtl/hs_rx_pkg.sv
// hs_rx_pkg: shared types, defaults and helpers for the hs_rx_mux receiver.
// Holds the channel FSM state encoding and the floored clog2 used for CH_W.
package hs_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } ch_state_e;

   localparam int unsigned DEF_NUM_CH         = 4;
   localparam int unsigned DEF_DATA_WIDTH     = 32;
   localparam int unsigned DEF_SYNC_STAGES    = 2;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int unsigned clog2_floor(input int unsigned n);
      return (n < 2) ? 1 : int'($clog2(n));
   endfunction

endpackage

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter, search starts one past the last grant.
// Ports: clk_i, rst_ni (sync, active-low), req[N], en -> grant (one-hot),
//        grant_idx, valid. last_grant advances only when en && valid.
module hs_rr_arbiter
   import hs_rx_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N-1:0]              req,
   input  logic                      en,
   output logic [N-1:0]              grant,
   output logic [clog2_floor(N)-1:0] grant_idx,
   output logic                      valid
);

   localparam int unsigned IW = clog2_floor(N);

   logic [IW-1:0] last_q;
   logic [IW-1:0] sel;
   int unsigned   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (int'(last_q) + 1 + k) % N;
         sel = IW'(idx);
         if (!valid && req[sel]) begin
            valid     = 1'b1;
            grant_idx = sel;
         end
      end
      if (valid) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= IW'(N - 1);
      end else if (en && valid) begin
         last_q <= grant_idx;
      end
   end

endmodule

// File: rtl/hs_rx_mux.sv
// hs_rx_mux: multi-channel four-phase req/ack CDC receiver merged onto one
// valid/ready stream. Inputs req_async/data_async from source domains;
// outputs ack per channel, out_valid/out_data/out_ch with out_ready,
// err_timeout (watchdog, built only when HS_RX_TIMEOUT_EN is defined).
module hs_rx_mux
   import hs_rx_pkg::*;
#(
   parameter  int unsigned NUM_CH         = DEF_NUM_CH,
   parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter  int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int unsigned CH_W           = clog2_floor(NUM_CH)
) (
   input  logic                         clk_dst,
   input  logic                         rst_dst_n,
   input  logic [NUM_CH-1:0]            req_async,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_async,
   output logic [NUM_CH-1:0]            ack,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   input  logic                         out_ready,
   output logic [NUM_CH-1:0]            err_timeout
);

   logic [NUM_CH-1:0]     req_sync;
   logic [NUM_CH-1:0]     arb_req;
   logic [NUM_CH-1:0]     arb_gnt_raw;
   logic [NUM_CH-1:0]     arb_gnt;
   logic [CH_W-1:0]       arb_idx;
   logic                  arb_valid;
   logic                  slot_free;
   logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [CH_W-1:0]       out_ch_q;

   assign slot_free = !out_valid_q || out_ready;
   // A grant only takes effect when the output slot can accept it.
   assign arb_gnt   = arb_gnt_raw & {NUM_CH{slot_free}};

   hs_rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk_i     (clk_dst),
      .rst_ni    (rst_dst_n),
      .req       (arb_req),
      .en        (slot_free),
      .grant     (arb_gnt_raw),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      ch_state_e              st_q;
      ch_state_e              st_d;
      logic                   ack_q;

      assign ch_data[i]  = data_async[i*DATA_WIDTH +: DATA_WIDTH];
      assign req_sync[i] = sync_q[SYNC_STAGES-1];
      assign arb_req[i]  = req_sync[i] && (st_q != ACK);
      assign ack[i]      = ack_q;

      always_comb begin
         st_d = st_q;
         case (st_q)
            IDLE: if (req_sync[i]) st_d = arb_gnt[i] ? ACK : PEND;
            // req dropping before grant is a source error: discard it.
            PEND: if (!req_sync[i]) st_d = IDLE;
                  else if (arb_gnt[i]) st_d = ACK;
            ACK:  if (!req_sync[i]) st_d = IDLE;
            default: st_d = IDLE;
         endcase
      end

      always_ff @(posedge clk_dst) begin
         if (!rst_dst_n) begin
            sync_q <= '0;
            st_q   <= IDLE;
            ack_q  <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async[i]};
            st_q   <= st_d;
            ack_q  <= (st_d == ACK);
         end
      end

`ifdef HS_RX_TIMEOUT_EN
      localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] cnt_q;
      logic          err_q;

      always_ff @(posedge clk_dst) begin
         if (!rst_dst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end else if (st_q == ACK && req_sync[i]) begin
            if (cnt_q != TW'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end

      assign err_timeout[i] = err_q;
`else
      assign err_timeout[i] = 1'b0;
`endif
   end

   always_ff @(posedge clk_dst) begin
      if (!rst_dst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else if (slot_free && arb_valid) begin
         out_valid_q <= 1'b1;
         out_data_q  <= ch_data[arb_idx];
         out_ch_q    <= arb_idx;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_hs_rx_mux.sv
// tb_hs_rx_mux: scoreboard bench for hs_rx_mux (4 channels, 2 sync stages).
// Directed latency/arbitration/backpressure/reset/watchdog checks.
module tb_hs_rx_mux;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int SS  = 2;
   localparam int TO  = 8;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] d;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] data;
   logic [NCH-1:0]    ack;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_ch;
   logic              out_ready;
   logic [NCH-1:0]    err;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_err = 0;
   logic exp_err;

   always #5 clk = ~clk;

   hs_rx_mux #(
      .NUM_CH         (NCH),
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_dst     (clk),
      .rst_dst_n   (rst_n),
      .req_async   (req),
      .data_async  (data),
      .ack         (ack),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .out_ready   (out_ready),
      .err_timeout (err)
   );

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #2;
   endtask

   task automatic samp(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int ch, input logic [31:0] d);
      data[ch*DW +: DW] = d;
      req[ch] = 1'b1;
      sb.push_back({2'(ch), d});
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            check("sb_ch", out_ch, e.ch);
            check("sb_data", out_data, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
`ifdef HS_RX_TIMEOUT_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_n = 1'b0;
      req = '0;
      data = '0;
      out_ready = 1'b1;
      go(); go(); go();
      samp();
      check("rst_valid", out_valid, 0);
      check("rst_ack", ack, 0);
      check("rst_data", out_data, 0);
      check("rst_ch", out_ch, 0);
      check("rst_err", err, 0);
      go(); rst_n = 1'b1;
      go(); go();

      // single transfer, latency and release
      go(); send(2, 32'hDEADBEEF);
      samp(3);
      check("t1_early_valid", out_valid, 0);
      check("t1_early_ack", ack, 0);
      samp();
      check("t1_valid", out_valid, 1);
      check("t1_ack", ack, 4'b0100);
      check("t1_ch", out_ch, 2);
      check("t1_data", out_data, 32'hDEADBEEF);
      samp(3);
      check("t1_ack_hold", ack, 4'b0100);
      check("t1_valid_clr", out_valid, 0);
      go(); req[2] = 1'b0;
      samp(3);
      check("t1_rel_early", ack, 4'b0100);
      samp();
      check("t1_rel", ack, 0);

      // simultaneous requests after reset: 0,1,3
      go(); rst_n = 1'b0;
      go(); rst_n = 1'b1;
      go();
      send(0, $urandom); send(1, $urandom); send(3, $urandom);
      samp(4);
      check("t2_first", {out_valid, out_ch}, {1'b1, 2'd0});
      samp();
      check("t2_second", {out_valid, out_ch}, {1'b1, 2'd1});
      samp();
      check("t2_third", {out_valid, out_ch}, {1'b1, 2'd3});
      check("t2_ack", ack, 4'b1011);
      samp();
      check("t2_drain", out_valid, 0);
      go(); req = '0;
      samp(4);
      check("t2_ack_rel", ack, 0);
      go(); send(1, $urandom);
      samp(4);
      check("t2_ch1", {out_valid, out_ch}, {1'b1, 2'd1});
      go(); req[1] = 1'b0;
      samp(4);
      // last_grant=1: channel 3 wins over 0
      go(); send(3, $urandom); send(0, $urandom);
      samp(4);
      check("t2b_first", {out_valid, out_ch}, {1'b1, 2'd3});
      samp();
      check("t2b_second", {out_valid, out_ch}, {1'b1, 2'd0});
      go(); req = '0;
      samp(4);

      // backpressure: last_grant=0 so channel 1 wins, 0 waits
      go(); out_ready = 1'b0;
      send(1, 32'hA5A5_0001); send(0, 32'h5A5A_0000);
      samp(4);
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_ch", {out_valid, out_ch}, {1'b1, 2'd1});
         check("t3_hold_data", out_data, 32'hA5A5_0001);
         check("t3_hold_ack", ack, 4'b0010);
         samp();
      end
      go(); out_ready = 1'b1;
      samp(2);
      check("t3_next", {out_valid, out_ch}, {1'b1, 2'd0});
      check("t3_next_ack", ack, 4'b0011);
      go(); req = '0;
      samp(4);

      // protocol violation on channel 3 while slot is blocked
      go(); out_ready = 1'b0; send(2, $urandom);
      samp(4);
      check("t4_blk", {out_valid, out_ch}, {1'b1, 2'd2});
      go(); data[3*DW +: DW] = 32'hBAD0_0003; req[3] = 1'b1;
      samp(3);
      go(); req[3] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         samp();
         check("t4_no_ack", ack[3], 0);
      end
      go(); out_ready = 1'b1;
      samp();
      for (int i = 0; i < 4; i++) begin
         samp();
         check("t4_no_valid", out_valid, 0);
         check("t4_no_ack3", ack[3], 0);
      end
      go(); req[2] = 1'b0;
      samp(4);

      // reset mid-transfer, word re-delivered
      go(); send(1, 32'h1234_5678);
      samp(4);
      check("t5_ack", ack, 4'b0010);
      go(); rst_n = 1'b0;
      go(); rst_n = 1'b1;
      samp();
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_ack", ack, 0);
      check("t5_rst_data", out_data, 0);
      check("t5_rst_ch", out_ch, 0);
      sb.push_back({2'd1, 32'h1234_5678});
      samp(2);
      check("t5_early", out_valid, 0);
      samp();
      check("t5_redeliver", {out_valid, out_ch}, {1'b1, 2'd1});
      check("t5_ack2", ack, 4'b0010);
      go(); req[1] = 1'b0;
      samp(4);

      // watchdog on channel 0
      go(); send(0, $urandom);
      samp(4);
      check("t6_ack", ack, 4'b0001);
      samp(7);
      check("t6_pre", err, 0);
      samp();
      check("t6_set", err, {3'b000, exp_err});
      samp(11);
      check("t6_hold_err", err, {3'b000, exp_err});
      check("t6_hold_ack", ack, 4'b0001);
      go(); req[0] = 1'b0;
      samp(4);
      check("t6_rel_ack", ack, 0);
      check("t6_sticky", err, {3'b000, exp_err});

      samp(3);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
